// File: rtl/bus_copy_ctrl.sv
// Bus-master block copier: reads words from a source range and writes them to a
// destination range over one master port, retrying any word whose grant drops.
module bus_copy_ctrl #(
  parameter int READ_LAT = 1,
  parameter int LEN_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       src_addr,
  input  logic [7:0]       dst_addr,
  input  logic [LEN_W-1:0] length,
  output logic             m_req,
  input  logic             m_grant,
  output logic [7:0]       m_address,
  output logic             m_wr,
  output logic [31:0]      m_dout,
  input  logic [31:0]      m_din,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    WR,
    DONE
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

  state_t           state_reg;
  logic [7:0]       src_reg;
  logic [7:0]       dst_reg;
  logic [31:0]      data_reg;
  logic [LEN_W-1:0] count_reg;
  logic [2:0]       lat_reg;

  logic [7:0]       src_inc;
  logic [7:0]       dst_inc;
  logic             last_word;

  assign src_inc   = src_reg + 8'd1;
  assign dst_inc   = dst_reg + 8'd1;
  assign last_word = (count_reg == LEN_W'(1));

  assign m_dout = data_reg;
  assign count  = count_reg;

  // Every bus-facing output is set on the transition into the state that owns it,
  // so nothing combinational reaches the ports from m_grant or m_din.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      data_reg  <= '0;
      count_reg <= '0;
      lat_reg   <= '0;
      m_req     <= 1'b0;
      m_address <= '0;
      m_wr      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            src_reg   <= src_addr;
            dst_reg   <= dst_addr;
            count_reg <= length;
            if (length != '0) begin
              state_reg <= REQ;
              m_req     <= 1'b1;
              m_wr      <= 1'b0;
              m_address <= src_addr;
              busy      <= 1'b1;
            end else begin
              state_reg <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end

        REQ: begin
          if (m_grant) begin
            state_reg <= RD;
            lat_reg   <= '0;
          end
        end

        RD: begin
          if (!m_grant) begin
            state_reg <= REQ;
          end else if (lat_reg == LAT_LAST) begin
            data_reg  <= m_din;
            state_reg <= WR;
            m_wr      <= 1'b1;
            m_address <= dst_reg;
          end else begin
            lat_reg <= lat_reg + 3'd1;
          end
        end

        WR: begin
          m_wr <= 1'b0;
          if (!m_grant) begin
            // Word abandoned: pointers untouched, re-read the same source word.
            state_reg <= REQ;
            m_address <= src_reg;
          end else begin
            src_reg   <= src_inc;
            dst_reg   <= dst_inc;
            m_address <= src_inc;
            if (count_reg != '0) begin
              count_reg <= count_reg - LEN_W'(1);
            end
            if (last_word || count_reg == '0) begin
              state_reg <= DONE;
              m_req     <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg <= RD;
              lat_reg   <= '0;
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          m_req     <= 1'b0;
          m_wr      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_copy_ctrl.sv
// Directed bench for bus_copy_ctrl with a 256-word behavioural slave on the bus.
module tb_bus_copy_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [7:0]  length;
  logic        m_req;
  logic        m_grant;
  logic [7:0]  m_address;
  logic        m_wr;
  logic [31:0] m_dout;
  logic [31:0] m_din;
  logic        busy;
  logic        done;
  logic [7:0]  count;

  always #5 clk = ~clk;

  bus_copy_ctrl #(.READ_LAT(1), .LEN_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .m_req(m_req), .m_grant(m_grant), .m_address(m_address), .m_wr(m_wr),
    .m_dout(m_dout), .m_din(m_din), .busy(busy), .done(done), .count(count)
  );

  logic [31:0] mem [256];
  int          wr_cnt [256];
  int          total_wr;
  int          done_cnt;
  bit          req_seen;
  logic        load_req = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [31:0] gold(int a);
    if (a == 0) return 32'h11;
    if (a == 1) return 32'h22;
    if (a == 2) return 32'h33;
    return 32'hD000_0000 | (32'(a) << 8) | 32'(a ^ 8'h5A);
  endfunction

  assign m_din = mem[m_address];

  // Slave model: a write lands only when the master holds the grant in its WR cycle.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]    = gold(i);
        wr_cnt[i] = 0;
      end
      total_wr = 0;
      done_cnt = 0;
      req_seen = 1'b0;
    end else begin
      if (m_req) req_seen = 1'b1;
      if (done) done_cnt++;
      if (m_req && m_wr && m_grant) begin
        mem[m_address] = m_dout;
        wr_cnt[m_address]++;
        total_wr++;
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    int         drop_k;
    int         restore_k;
    int         restart_k;
    int         exp_k;
  } vec_t;

  vec_t tbl [9];

  task automatic load_slave();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] expm [256];
    int got = 0;
    int bad_words = 0;
    int bad_once = 0;
    load_slave();
    m_grant  = 1'b1;
    start    = 1'b1;
    src_addr = v.src;
    dst_addr = v.dst;
    length   = v.len;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        start = 1'b0;
        if (v.len != 0)
          chk($sformatf("v%0d first_rd", idx), {m_req, m_wr, m_address, count, busy},
              {1'b1, 1'b0, v.src, v.len, 1'b1});
      end
      if (k == v.restart_k) begin
        start = 1'b1; src_addr = 8'h40; dst_addr = 8'hC0; length = 8'd2;
      end
      if (v.restart_k != 0 && k == v.restart_k + 1) start = 1'b0;
      if (k == v.drop_k) m_grant = 1'b0;
      if (k == v.restore_k) m_grant = 1'b1;
      if (done) begin
        got = k;
        break;
      end
    end
    chk($sformatf("v%0d done_cycle", idx), 64'(got), 64'(v.exp_k));
    chk($sformatf("v%0d done_state", idx), {busy, count}, {1'b0, 8'd0});
    repeat (4) @(posedge clk);
    #1;
    chk($sformatf("v%0d single_done", idx), {32'(done_cnt), m_req, busy}, {32'd1, 1'b0, 1'b0});
    chk($sformatf("v%0d req_seen", idx), 64'(req_seen), 64'(v.len != 0));
    for (int i = 0; i < 256; i++) expm[i] = gold(i);
    for (int i = 0; i < int'(v.len); i++) expm[(int'(v.dst) + i) & 255] = gold((int'(v.src) + i) & 255);
    for (int i = 0; i < 256; i++) if (mem[i] !== expm[i]) bad_words++;
    for (int i = 0; i < int'(v.len); i++) if (wr_cnt[(int'(v.dst) + i) & 255] != 1) bad_once++;
    chk($sformatf("v%0d contents_bad_words", idx), 64'(bad_words), 64'd0);
    chk($sformatf("v%0d writes", idx), {32'(total_wr), 32'(bad_once)}, {32'(v.len), 32'd0});
  endtask

  initial begin
    // done cycle k: 1 REQ + 2 per word (RD, WR) + the DONE cycle; grant outages add cycles.
    tbl[0] = '{8'h00, 8'h20, 8'd3,  0, 0, 0, 8};
    tbl[1] = '{8'hFE, 8'h10, 8'd3,  0, 0, 0, 8};
    tbl[2] = '{8'h40, 8'h80, 8'd0,  0, 0, 0, 1};
    tbl[3] = '{8'h50, 8'h90, 8'd1,  0, 0, 0, 4};
    tbl[4] = '{8'h60, 8'hA0, 8'd5,  0, 0, 0, 12};
    tbl[5] = '{8'hF0, 8'h08, 8'd16, 0, 0, 0, 34};
    tbl[6] = '{8'h00, 8'h20, 8'd3,  5, 7, 0, 12};
    tbl[7] = '{8'h50, 8'h90, 8'd2,  2, 3, 0, 8};
    tbl[8] = '{8'h00, 8'h20, 8'd3,  0, 0, 3, 8};

    reset_n  = 1'b0;
    start    = 1'b0;
    src_addr = 8'h00;
    dst_addr = 8'h00;
    length   = 8'd0;
    m_grant  = 1'b1;
    #1;
    chk("reset_state", {m_req, m_address, m_wr, m_dout, busy, done, count},
        {1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // Reset in the RD cycle of word 2: two words already written, no done pulse.
    load_slave();
    start = 1'b1; src_addr = 8'h00; dst_addr = 8'h20; length = 8'd3;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
    end
    chk("pre_reset_rd2", {m_req, m_wr, m_address, count}, {1'b1, 1'b0, 8'h02, 8'd1});
    reset_n = 1'b0;
    #1;
    chk("async_reset", {m_req, busy, done, count}, {1'b0, 1'b0, 1'b0, 8'd0});
    repeat (3) @(posedge clk);
    #1;
    chk("reset_partial", {32'(done_cnt), 32'(total_wr)}, {32'd0, 32'd2});
    chk("reset_kept_words", {mem[8'h20], mem[8'h21], mem[8'h22]},
        {32'h11, 32'h22, gold(8'h22)});
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(tbl[0], 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
